// File: rtl/minisys_pkg.sv
// rtl/minisys_pkg.sv - shared Minisys-1A encodings for the write-back stage
package minisys_pkg;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-stage to write-back-stage handshake and payload bus
interface wb_stage_if;
  import minisys_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [31:0] in_pc_plus4;
  logic [4:0]  in_waddr;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic        in_link;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic        stall;
  logic        flush;

  modport master (
    output in_valid, in_alu_result, in_mem_rdata, in_pc_plus4, in_waddr,
           in_regwrite, in_memtoreg, in_link, in_ld_size, in_ld_unsigned,
           stall, flush,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_alu_result, in_mem_rdata, in_pc_plus4, in_waddr,
           in_regwrite, in_memtoreg, in_link, in_ld_size, in_ld_unsigned,
           stall, flush,
    output in_ready
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - little-endian lane select with sign/zero extension
module load_align
  import minisys_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'd0;
    case (addr_lo)
      2'b00:   lane_b = rdata[7:0];
      2'b01:   lane_b = rdata[15:8];
      2'b10:   lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // The reserved size code falls through to a full-word load.
  always_comb begin
    data = rdata;
    case (size)
      LD_BYTE: data = {{24{lane_b[7] & ~ld_unsigned}}, lane_b};
      LD_HALF: data = {{16{lane_h[15] & ~ld_unsigned}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - Minisys-1A write-back stage: result select, register-file write port, retire counter
module wb_stage
  import minisys_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  wb_stage_if.slave           mem,
  output logic                wb_valid,
  output logic [31:0]         wb_data,
  output logic [4:0]          wb_waddr,
  output logic                RegWrite,
  output logic                misalign,
  output logic [RETIRE_W-1:0] retire_count
);

  logic [31:0] load_data;
  logic [31:0] data_next;
  logic        misalign_next;
  logic        capture;
  logic        write_next;

  load_align u_load_align (
    .rdata       (mem.in_mem_rdata),
    .addr_lo     (mem.in_alu_result[1:0]),
    .size        (mem.in_ld_size),
    .ld_unsigned (mem.in_ld_unsigned),
    .data        (load_data)
  );

  assign mem.in_ready = !mem.stall;
  assign capture      = mem.in_valid && !mem.stall && !mem.flush;

  always_comb begin
    misalign_next = 1'b0;
    if (mem.in_memtoreg && !mem.in_link) begin
      case (mem.in_ld_size)
        LD_HALF: misalign_next = mem.in_alu_result[0];
        LD_BYTE: misalign_next = 1'b0;
        default: misalign_next = (mem.in_alu_result[1:0] != 2'b00);
      endcase
    end
  end

  always_comb begin
    data_next = mem.in_alu_result;
    if (mem.in_link)
      data_next = mem.in_pc_plus4;
    else if (mem.in_memtoreg)
      data_next = load_data;
  end

  // Write enable is resolved before the register so RegWrite is a clean flop output.
  assign write_next = mem.in_regwrite && !misalign_next && (mem.in_waddr != REG_ZERO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_waddr     <= REG_ZERO;
      RegWrite     <= 1'b0;
      misalign     <= 1'b0;
      retire_count <= '0;
    end else if (capture) begin
      wb_valid <= 1'b1;
      wb_data  <= data_next;
      wb_waddr <= mem.in_waddr;
      RegWrite <= write_next;
      misalign <= misalign_next;
      if (!misalign_next)
        retire_count <= retire_count + RETIRE_W'(1);
    end else begin
      wb_valid <= 1'b0;
      RegWrite <= 1'b0;
      misalign <= 1'b0;
    end
  end

endmodule
